bitstream_serializer: RTL and testbench
=======================================

# bitstream_serializer

Parallel-to-serial front end for the bit-serial sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `out`, which drives the detector's `in`. A one-word holding register lets back-to-back words stream with no idle gap. Between words, `out` carries a fixed idle level so the downstream detector sees a defined stream.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, 0: value driven on `out` whenever no word is being shifted.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `din`  in  WIDTH  word to serialize.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word this cycle.
- `out`  out  1  serial bit to the downstream detector `in`.
- `out_valid`  out  1  `out` carries a data bit rather than idle fill.
- `word_done`  out  1  high during the cycle the last bit of a word is on `out`.
- `busy`  out  1  shifting, or a word is held pending.

## Operation
- State registers:
  - `state` ∈ {IDLE, SHIFT}.
  - Shift register `sreg[WIDTH-1:0]`.
  - Bit counter `cnt`, clog2(WIDTH) bits, counting 0..WIDTH-1.
  - Holding register `pend[WIDTH-1:0]` with flag `pend_full`.
- Handshake:
  - `din_ready = rst & !pend_full`.
  - A transfer occurs on an edge where `din_valid & din_ready` is high.
  - `din` may change freely when `din_valid` is low.
- Output decode, from registers only:
  - `out_valid = (state==SHIFT)`.
  - `out = out_valid ? current bit : IDLE_BIT`. The current bit is `sreg[WIDTH-1]` when MSB_FIRST=1, else `sreg[0]`.
  - `word_done = out_valid & (cnt==WIDTH-1)`.
  - `busy = out_valid | pend_full`.
- IDLE state:
  - A transfer loads `din` into `sreg`, sets `cnt=0`, and moves to SHIFT.
  - `pend` is unused in IDLE.
- SHIFT state, when `cnt < WIDTH-1`:
  - Shift `sreg` one position toward the output end and increment `cnt`.
  - A transfer stores `din` into `pend` and sets `pend_full`.
- SHIFT state, last bit (`cnt == WIDTH-1`):
  - If `pend_full`: load `pend` into `sreg`, set `cnt=0`, stay in SHIFT. If a transfer also occurs on this edge, `din` goes into `pend` and `pend_full` stays 1; otherwise `pend_full` clears.
  - Else if a transfer occurs: load `din` directly into `sreg` (bypass), set `cnt=0`, stay in SHIFT.
  - Else: go to IDLE.
- Bit order within a word is strictly preserved. Word order is strictly FIFO. No word is ever dropped or duplicated.

## Timing
- Reset: when `rst` is sampled low, the block enters IDLE with `cnt=0`, `sreg=0`, `pend=0` and `pend_full=0`.
- Outputs after reset: `out=IDLE_BIT`, `out_valid=0`, `word_done=0`, `busy=0`. `din_ready` is 0 while `rst` is low and 1 on the first cycle after release.
- Reset mid-word: the in-flight word and any pending word are discarded with no further bits emitted. A transfer offered on the reset edge is ignored.
- Latency: a word accepted at edge k from IDLE has its first bit on `out` in cycle k+1 and its last bit in cycle k+WIDTH, with `word_done` high in cycle k+WIDTH.
- Back-to-back:
  - Word N+1's first bit immediately follows word N's last bit in the next cycle; no idle bit is inserted.
  - This holds whether word N+1 came from `pend` or arrived on the last-bit edge.
- Throughput: one word per WIDTH cycles sustained.
- `din_ready` drops for the cycle after `pend` fills. It reasserts in the cycle after the last-bit edge that drains `pend`.

## Test plan
- Reset and idle: hold `rst`=0 for 3 cycles, then release with `din_valid`=0. Required: `out`=IDLE_BIT, `out_valid`=0, `busy`=0 on every cycle; `din_ready`=0 during reset and 1 after release.
- Single word, MSB_FIRST=1, WIDTH=8: send `din`=8'hCE once. Required: `out` sequence 1,1,0,0,1,1,1,0 in cycles k+1..k+8; `word_done` only in cycle k+8; then idle fill.
- Detector chain: wire `out` to the 1100111 detector and send 8'hCE. Required: the detector output pulses exactly once, on the seventh data bit.
- Streaming: present 8'hA5, 8'h3C, 8'hFF with `din_valid` held high. Required:
  - 24 contiguous valid bits 10100101 00111100 11111111.
  - `din_ready` low while `pend` is full.
  - `word_done` in cycles k+8, k+16 and k+24.
- LSB-first: with MSB_FIRST=0, send 8'h01. Required: `out` sequence 1,0,0,0,0,0,0,0.
- Mid-word reset: send 8'hF0, plus a second word held pending. Assert `rst`=0 on the edge after the 3rd bit is shown. Required: from the next cycle, `out`=IDLE_BIT, `out_valid`=0, `busy`=0; neither word resumes.

Source files
------------

// File: rtl/bitstream_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
// The serializer takes the slave view; the producer or bench takes the master view.
interface bitstream_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             out;
    logic             out_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, out, out_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, out, out_valid, word_done, busy
    );
endinterface

// File: rtl/bitstream_serializer.sv
// Parallel-to-serial front end for the bit-serial detectors. A one-word holding
// register lets consecutive words leave with no idle bit between them.
module bitstream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    bitstream_serializer_if.slave         bus
);
    localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             pend_full_reg, pend_full_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shifted;
    logic             xfer;

    // Shift one position toward whichever end feeds out; the vacated end fills with 0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = sreg_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = sreg_reg[gi+1];
            end
        end
    end

    assign bus.din_ready = rst & ~pend_full_reg;
    assign xfer          = bus.din_valid & bus.din_ready;

    assign bus.out_valid = (state_reg == SHIFT);
    assign bus.out       = bus.out_valid ? sreg_reg[OUT_IDX] : IDLE_BIT;
    assign bus.word_done = bus.out_valid & (cnt_reg == LAST);
    assign bus.busy      = bus.out_valid | pend_full_reg;

    always_comb begin
        state_next     = state_reg;
        sreg_next      = sreg_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        cnt_next       = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    sreg_next  = bus.din;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg != LAST) begin
                    sreg_next = shifted;
                    cnt_next  = cnt_reg + 1'b1;
                    if (xfer) begin
                        pend_next      = bus.din;
                        pend_full_next = 1'b1;
                    end
                end else if (pend_full_reg) begin
                    // Held word goes next so FIFO order survives a same-edge arrival.
                    sreg_next = pend_reg;
                    cnt_next  = '0;
                    if (xfer) begin
                        pend_next = bus.din;
                    end else begin
                        pend_full_next = 1'b0;
                    end
                end else if (xfer) begin
                    sreg_next = bus.din;
                    cnt_next  = '0;
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sreg_reg      <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            sreg_reg      <= sreg_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            cnt_reg       <= cnt_next;
        end
    end
endmodule

// File: tb/tb_bitstream_serializer.sv
// Bench for bitstream_serializer: a queue-of-bits reference model, a vector table,
// and directed streaming / mid-word reset sequences.
module tb_bitstream_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bitstream_serializer_if #(.WIDTH(W)) a_if ();
    bitstream_serializer_if #(.WIDTH(W)) b_if ();

    bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    int errors = 0;
    int checks = 0;
    logic q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check dut_a against the bit queue, drive inputs, update the model.
    task automatic step(input logic r, input logic av, input logic [W-1:0] ad,
                        input logic bv, input logic [W-1:0] bd, output logic acc);
        int sz;
        logic ev;
        sz = q.size();
        ev = (sz > 0);
        chk("out_valid", a_if.out_valid, ev);
        chk("out", a_if.out, ev ? q[0] : 1'b0);
        chk("word_done", a_if.word_done, ev && (sz % W == 1));
        chk("busy", a_if.busy, ev);
        chk("din_ready", a_if.din_ready, rst && (sz <= W));
        rst = r;
        a_if.din_valid = av;
        a_if.din = ad;
        b_if.din_valid = bv;
        b_if.din = bd;
        acc = r && av && (sz <= W);
        @(posedge clk);
        if (!r) begin
            q.delete();
        end else begin
            if (sz > 0) void'(q.pop_front());
            if (acc) for (int i = W - 1; i >= 0; i--) q.push_back(ad[i]);
        end
        @(negedge clk);
        $display("cycle t=%0t rst=%0b a_valid=%0b a_din=%02h acc=%0b out=%0b out_valid=%0b",
                 $time, r, av, ad, acc, a_if.out, a_if.out_valid);
    endtask

    typedef struct {
        bit         lsb;
        logic [7:0] din;
        logic [7:0] exp_seq;   // first emitted bit at [7]
        int         det_at;    // data-bit index where 1100111 completes, -1 for none
    } vec_t;
    vec_t vecs[4];

    initial begin
        logic acc;
        logic o, ov, wd;
        logic [6:0] hist;
        int dets, det_i, idx, n;
        logic started, saw_low;
        logic [7:0] words[3];
        logic sv[26], so[26], sd[26];
        logic [23:0] exp_stream;

        vecs[0] = '{1'b0, 8'hCE, 8'b11001110, 6};
        vecs[1] = '{1'b0, 8'h96, 8'b10010110, -1};
        vecs[2] = '{1'b1, 8'h01, 8'b10000000, -1};
        vecs[3] = '{1'b1, 8'hCE, 8'b01110011, -1};
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        exp_stream = 24'hA53CFF;

        a_if.din_valid = 1'b0; a_if.din = '0;
        b_if.din_valid = 1'b0; b_if.din = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held, then released idle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, '0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        chk("ready_after_rst", a_if.din_ready, 1'b1);

        // Vector table: single words on either instance, plus the 1100111 detector.
        for (int v = 0; v < 4; v++) begin
            step(1'b1, !vecs[v].lsb, vecs[v].din, vecs[v].lsb, vecs[v].din, acc);
            hist = '0; dets = 0; det_i = -1;
            for (int i = 0; i < 10; i++) begin
                o  = vecs[v].lsb ? b_if.out       : a_if.out;
                ov = vecs[v].lsb ? b_if.out_valid : a_if.out_valid;
                wd = vecs[v].lsb ? b_if.word_done : a_if.word_done;
                hist = {hist[5:0], o};
                if (ov && hist == 7'b1100111) begin
                    dets++;
                    det_i = i;
                end
                if (i < 8) begin
                    chk("vec_bit", o, vecs[v].exp_seq[7-i]);
                    chk("vec_valid", ov, 1'b1);
                    chk("vec_done", wd, i == 7);
                end else begin
                    chk("vec_idle_valid", ov, 1'b0);
                    chk("vec_idle_out", o, 1'b0);
                end
                step(1'b1, 1'b0, '0, 1'b0, '0, acc);
            end
            if (!vecs[v].lsb) begin
                chk("det_count", dets, (vecs[v].det_at >= 0) ? 1 : 0);
                if (vecs[v].det_at >= 0) chk("det_pos", det_i, vecs[v].det_at);
            end
        end

        // Streaming three words with din_valid held high.
        idx = 0; n = 0; started = 1'b0; saw_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (started && n < 26) begin
                sv[n] = a_if.out_valid; so[n] = a_if.out; sd[n] = a_if.word_done;
                if (!a_if.din_ready) saw_low = 1'b1;
                n++;
            end
            step(1'b1, idx < 3, (idx < 3) ? words[idx] : 8'h00, 1'b0, '0, acc);
            if (acc) begin
                idx++;
                started = 1'b1;
            end
        end
        chk("stream_accepted", idx, 3);
        chk("stream_ready_low", saw_low, 1'b1);
        for (int i = 0; i < 26; i++) begin
            if (i < 24) begin
                chk("stream_valid", sv[i], 1'b1);
                chk("stream_bit", so[i], exp_stream[23-i]);
                chk("stream_done", sd[i], (i % 8) == 7);
            end else begin
                chk("stream_tail_valid", sv[i], 1'b0);
            end
        end

        // Mid-word reset with a second word pending.
        step(1'b1, 1'b1, 8'hF0, 1'b0, '0, acc);
        chk("mid_acc0", acc, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0, '0, acc);
        chk("mid_acc1", acc, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        step(1'b0, 1'b1, 8'hAA, 1'b0, '0, acc);
        for (int i = 0; i < 12; i++) begin
            chk("mid_out_valid", a_if.out_valid, 1'b0);
            chk("mid_busy", a_if.busy, 1'b0);
            chk("mid_out", a_if.out, 1'b0);
            step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), 1'b0, '0, acc);
        end
        for (int c = 0; c < 12; c++) step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        chk("final_idle", a_if.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
